// File: rtl/to_lower_stream_if.sv
// Byte-stream handshake bundle: upstream input side and downstream output side.
interface to_lower_stream_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/to_lower_stream.sv
// Buffered ASCII lowercase converter: converts at accept time, queues results
// in a small FIFO, and keeps wrapping/saturating byte statistics.
module to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  to_lower_stream_if.slave s,
  input  logic             conv_en,
  input  logic             cnt_clr,
  output logic [CW-1:0]    byte_count,
  output logic [CW-1:0]    conv_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          arm_q;
  logic [CW-1:0] byte_q, byte_d, conv_q, conv_d;
  logic          acc, emit, hit;
  logic [7:0]    cdata;

  // arm_q holds in_ready low through reset and releases it on the first edge after
  assign s.in_ready   = arm_q && (occ_q < OW'(DEPTH));
  assign s.out_valid  = (occ_q != '0);
  assign s.out_data   = s.out_valid ? mem_q[rd_q] : 8'h00;
  assign byte_count   = byte_q;
  assign conv_count   = conv_q;

  assign acc  = s.in_valid  && s.in_ready;
  assign emit = s.out_valid && s.out_ready;

  always_comb begin
    hit    = conv_en && (s.in_data >= 8'd65) && (s.in_data <= 8'd90);
    cdata  = hit ? (s.in_data + 8'd32) : s.in_data;
    rd_d   = emit ? (rd_q + AW'(1)) : rd_q;
    wr_d   = acc  ? (wr_q + AW'(1)) : wr_q;
    occ_d  = occ_q;
    case ({acc, emit})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    byte_d = byte_q;
    conv_d = conv_q;
    if (cnt_clr) begin
      byte_d = '0;
      conv_d = '0;
    end else if (acc) begin
      byte_d = byte_q + CW'(1);
      if (hit && (conv_q != '1)) conv_d = conv_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      occ_q  <= '0;
      arm_q  <= 1'b0;
      byte_q <= '0;
      conv_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      occ_q  <= occ_d;
      arm_q  <= 1'b1;
      byte_q <= byte_d;
      conv_q <= conv_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= cdata;
  end
endmodule

// File: tb/tb_to_lower_stream.sv
// Directed + random bench with a queue-based reference model of the converter.
module tb_to_lower_stream;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          conv_en = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] byte_count, conv_count;

  to_lower_stream_if bus();

  to_lower_stream #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus),
    .conv_en    (conv_en),
    .cnt_clr    (cnt_clr),
    .byte_count (byte_count),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mq[$];
  logic [7:0] obs[$];
  logic [7:0] src[$];
  logic [7:0] expq[$];
  int         m_bytes = 0;
  int         m_conv  = 0;
  bit         armed   = 0;

  function automatic logic [7:0] lower(logic [7:0] c, bit en);
    if (en && c >= 8'd65 && c <= 8'd90) return c - 8'd65 + 8'd97;
    return c;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bytes = 0;
    m_conv  = 0;
    armed   = 0;
  endtask

  task automatic check_state();
    chk("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_data", bus.out_data, mq[0]);
    chk("in_ready", bus.in_ready, armed && mq.size() < DEPTH);
    chk("byte_count", byte_count, m_bytes);
    chk("conv_count", conv_count, m_conv);
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic cyc(bit v, logic [7:0] d, bit ordy, bit cen, bit clr, output bit acc);
    bit emit;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    conv_en       = cen;
    cnt_clr       = clr;
    acc  = v && armed && mq.size() < DEPTH;
    emit = mq.size() > 0 && ordy;
    if (bus.out_valid && ordy) obs.push_back(bus.out_data);
    @(posedge clk);
    if (emit) void'(mq.pop_front());
    if (acc) mq.push_back(lower(d, cen));
    if (clr) begin
      m_bytes = 0;
      m_conv  = 0;
    end else if (acc) begin
      m_bytes = (m_bytes + 1) % (1 << CW);
      if (lower(d, cen) != d && m_conv < (1 << CW) - 1) m_conv++;
    end
    armed = 1;
    @(negedge clk);
    check_state();
  endtask

  task automatic offer(bit ordy, bit cen, int maxc);
    int  idx = 0;
    int  n   = 0;
    bit  a;
    while (idx < src.size() && n < maxc) begin
      cyc(1'b1, src[idx], ordy, cen, 1'b0, a);
      if (a) idx++;
      n++;
    end
    chk("offer_done", idx, src.size());
  endtask

  task automatic drain(int maxc);
    int n = 0;
    bit a;
    while (mq.size() > 0 && n < maxc) begin
      cyc(1'b0, 8'h00, 1'b1, conv_en, 1'b0, a);
      n++;
    end
    chk("drained", bus.out_valid, 1'b0);
  endtask

  task automatic clear_stats();
    bit a;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, a);
    obs.delete();
  endtask

  task automatic cmp_obs(string tag);
    chk({tag, "_len"}, obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++) chk(tag, obs[i], expq[i]);
  endtask

  initial begin
    bit         a;
    int         idx;
    logic [7:0] head;

    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    model_reset();
    #1;
    chk("rst_out_data", bus.out_data, 8'h00);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", bus.in_ready, 1'b0);

    // Mixed-case stream with conversion on
    clear_stats();
    src  = '{8'd72, 8'd97, 8'd65, 8'd122, 8'd71, 8'd109, 8'd40, 8'd183};
    expq = '{8'd104, 8'd97, 8'd97, 8'd122, 8'd103, 8'd109, 8'd40, 8'd183};
    offer(1'b1, 1'b1, 40);
    chk("s1_bytes", byte_count, 8);
    chk("s1_conv", conv_count, 3);
    drain(20);
    cmp_obs("s1_out");

    // Pass-through at the letter boundaries
    clear_stats();
    src  = '{8'd65, 8'd90, 8'd64, 8'd91};
    expq = '{8'd65, 8'd90, 8'd64, 8'd91};
    offer(1'b1, 1'b0, 20);
    chk("s2_bytes", byte_count, 4);
    chk("s2_conv", conv_count, 0);
    drain(20);
    cmp_obs("s2_out");

    // Back-pressure: fill, hold head, then drain and accept the rest
    clear_stats();
    src  = '{8'd66, 8'd99, 8'd68, 8'd101, 8'd70, 8'd103};
    expq = '{8'd98, 8'd99, 8'd100, 8'd101, 8'd102, 8'd103};
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, src[idx], 1'b0, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("full_accepted", idx, 4);
    chk("full_rdy", bus.in_ready, 1'b0);
    head = bus.out_data;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, src[idx], 1'b0, 1'b1, 1'b0, a);
      chk("head_hold", bus.out_data, head);
      chk("valid_hold", bus.out_valid, 1'b1);
    end
    for (int i = 0; i < 20 && idx < 6; i++) begin
      cyc(1'b1, src[idx], 1'b1, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_all_accepted", idx, 6);
    drain(20);
    cmp_obs("bp_out");

    // Full FIFO streaming 20 bytes with pointer wrap
    clear_stats();
    src.delete(); expq.delete();
    for (int i = 0; i < 20; i++) begin
      src.push_back(8'($urandom_range(0, 255)));
      expq.push_back(lower(src[i], 1'b1));
    end
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, src[idx], 1'b0, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("wrap_full", bus.in_ready, 1'b0);
    for (int i = 0; i < 60 && idx < 20; i++) begin
      cyc(1'b1, src[idx], 1'b1, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("wrap_accepted", idx, 20);
    drain(20);
    cmp_obs("wrap_out");

    // Counter wrap / saturation and clear priority
    clear_stats();
    src.delete();
    for (int i = 0; i < 17; i++) src.push_back(8'd65);
    offer(1'b1, 1'b1, 40);
    chk("cnt_wrap", byte_count, 1);
    chk("cnt_sat", conv_count, 15);
    cyc(1'b1, 8'd65, 1'b1, 1'b1, 1'b1, a);
    chk("clr_acc", a, 1'b1);
    chk("clr_bytes", byte_count, 0);
    chk("clr_conv", conv_count, 0);
    drain(20);

    // Asynchronous reset mid-stream
    clear_stats();
    src = '{8'd1, 8'd2, 8'd3};
    offer(1'b0, 1'b1, 10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", bus.out_valid, 1'b0);
    chk("ar_rdy", bus.in_ready, 1'b0);
    chk("ar_data", bus.out_data, 8'h00);
    chk("ar_bytes", byte_count, 0);
    chk("ar_conv", conv_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rdy_rel", bus.in_ready, 1'b0);
    obs.delete();
    cyc(1'b1, 8'd81, 1'b1, 1'b1, 1'b0, a);
    src  = '{8'd81, 8'd50};
    expq = '{8'd113, 8'd50};
    offer(1'b1, 1'b1, 10);
    drain(10);
    cmp_obs("ar_out");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 31) == 0, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
